// File: rtl/bluetooth_tx.sv
// bluetooth_tx: UART transmitter toward the HC-05 RX pin, fed by a small byte FIFO.
// Define BLUETOOTH_TX_PARITY_EN to insert an even-parity bit (8E1); otherwise 8N1 frames.
module bluetooth_tx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        TxD,
  output logic                        busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  // state  | meaning
  // IDLE   | line high, waiting for the FIFO to hold a byte
  // START  | start bit (low) for one bit period
  // DATA   | eight data bits, LSB first, one bit period each
  // PARITY | even parity bit (only reachable with BLUETOOTH_TX_PARITY_EN)
  // STOP   | stop bit (high); chains straight into START if more bytes wait

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_TICK = CW'(DIV - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
  logic            done_q, done_d;
`ifdef BLUETOOTH_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;

  logic            push;
  logic            pop;
  logic            tick_end;
  logic            fifo_empty;

  assign fifo_empty = (count_q == '0);
  assign tx_ready   = (count_q != FULL_CNT);
  assign push       = tx_valid && tx_ready;
  assign tick_end   = (cnt_q == LAST_TICK);

  assign TxD        = txd_q;
  assign tx_done    = done_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    pop     = 1'b0;
`ifdef BLUETOOTH_TX_PARITY_EN
    par_d   = par_q;
`endif

    // Every transition happens on the last tick, so wrapping here also clears the counter on state change.
    if (state_q != S_IDLE) begin
      cnt_d = tick_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
`ifdef BLUETOOTH_TX_PARITY_EN
          par_d   = ^mem_q[rd_ptr_q];
`endif
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tick_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef BLUETOOTH_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef BLUETOOTH_TX_PARITY_EN
      S_PARITY: begin
        if (tick_end) begin
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick_end) begin
          done_d = 1'b1;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
`ifdef BLUETOOTH_TX_PARITY_EN
            par_d   = ^mem_q[rd_ptr_q];
`endif
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The line is registered, so it shows the bit of the state held on the previous cycle.
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_q[0];
`ifdef BLUETOOTH_TX_PARITY_EN
      S_PARITY: txd_d = par_q;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      done_q   <= 1'b0;
`ifdef BLUETOOTH_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      done_q   <= done_d;
`ifdef BLUETOOTH_TX_PARITY_EN
      par_q    <= par_d;
`endif
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

endmodule

// File: tb/tb_bluetooth_tx.sv
// Directed bench for bluetooth_tx: a line monitor decodes frames and checks them against a byte scoreboard.
`timescale 1ns/1ps
module tb_bluetooth_tx;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int DEPTH    = 4;
`ifdef BLUETOOTH_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       TxD;
  logic       busy;
  logic       tx_done;
  logic [2:0] fifo_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_done = 0;
  int mon_frames = 0;
  logic [7:0] sb [$];
  int   mon_start [$];
  int   mon_end [$];
  logic mon_par [$];

  bluetooth_tx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD(BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .TxD(TxD),
    .busy(busy),
    .tx_done(tx_done),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst === 1'b1 && tx_done === 1'b1) n_done <= n_done + 1;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on the negedge where the start bit is first seen (frame cycle 0).
  task automatic decode_frame();
    logic [NB-1:0] ebits;
    logic [7:0]    exp_b;
    logic [7:0]    rx;
    logic          have;
    logic          bad;
    logic          par;
    int            start_c;
    have = (sb.size() != 0);
    chk("frame_expected", 32'(have), 32'd1);
    exp_b = 8'h00;
    if (have) exp_b = sb.pop_front();
    ebits       = '1;
    ebits[0]    = 1'b0;
    ebits[8:1]  = exp_b;
`ifdef BLUETOOTH_TX_PARITY_EN
    ebits[9]    = ^exp_b;
`endif
    start_c = cyc;
    bad = 1'b0;
    rx  = 8'h00;
    par = 1'b0;
    for (int c = 0; c < FRAME; c++) begin
      if (c > 0) @(negedge clk);
      if (rst !== 1'b1) return;
      if (TxD !== ebits[c / DIV]) bad = 1'b1;
      if (tx_done !== (c == FRAME - 1)) bad = 1'b1;
      if ((c % DIV) == DIV / 2 && (c / DIV) >= 1 && (c / DIV) <= 8) rx[(c / DIV) - 1] = TxD;
      if (c == 9 * DIV + DIV / 2) par = TxD;
    end
    mon_frames++;
    mon_start.push_back(start_c);
    mon_end.push_back(cyc);
    mon_par.push_back(par);
    chk("frame_shape", 32'(bad), 32'd0);
    chk("frame_byte", 32'(rx), 32'(exp_b));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && TxD === 1'b0) decode_frame();
    end
  end

  task automatic push(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && t < 4 * FRAME) begin
      @(negedge clk);
      t++;
    end
    chk("push_ready", 32'(tx_ready), 32'd1);
    sb.push_back(b);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int t = 0;
    @(negedge clk);
    while (busy !== 1'b0 && t < limit) begin
      @(negedge clk);
      t++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int   base;
    int   d0;
    int   t;
    int   n_acc;
    logic bad;
    logic seen_full;
    logic seen_rise;

    // 1: reset, then idle
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (TxD !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0 || fifo_count !== 3'd0) bad = 1'b1;
    end
    chk("rst_txd", 32'(TxD), 32'd1);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_hold", 32'(bad), 32'd0);
    rst = 1'b1;
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (TxD !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0 || fifo_count !== 3'd0) bad = 1'b1;
    end
    chk("idle_quiet", 32'(bad), 32'd0);

    // 2: single byte 0x55 with exact latency and stop timing
    base = mon_frames;
    d0   = n_done;
    @(negedge clk);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    sb.push_back(8'h55);
    @(negedge clk);
    tx_valid = 1'b0;
    chk("lat_count_n", 32'(fifo_count), 32'd1);
    chk("lat_txd_n", 32'(TxD), 32'd1);
    @(negedge clk);
    chk("lat_count_n1", 32'(fifo_count), 32'd0);
    chk("lat_txd_n1", 32'(TxD), 32'd1);
    chk("lat_busy_n1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("lat_txd_n2", 32'(TxD), 32'd0);
    repeat (FRAME - 2) @(negedge clk);
    chk("done_early", 32'(tx_done), 32'd0);
    chk("busy_in_frame", 32'(busy), 32'd1);
    @(negedge clk);
    chk("done_last_cycle", 32'(tx_done), 32'd1);
    chk("busy_fall", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(tx_done), 32'd0);
    chk("txd_idle_after", 32'(TxD), 32'd1);
    repeat (2) @(negedge clk);
    chk("single_frames", 32'(mon_frames - base), 32'd1);
    chk("single_done", 32'(n_done - d0), 32'd1);

    // 3: burst 0x01..0x06 with valid held. The idle pop on the second accept
    // edge frees one slot, so the FIFO fills on the fifth accept.
    base      = mon_frames;
    d0        = n_done;
    n_acc     = 0;
    seen_full = 1'b0;
    seen_rise = 1'b0;
    t         = 0;
    @(negedge clk);
    tx_data  = 8'h01;
    tx_valid = 1'b1;
    while (n_acc < 6 && t < 20 * FRAME) begin
      if (tx_ready === 1'b1) begin
        if (seen_full && !seen_rise) begin
          seen_rise = 1'b1;
          chk("ready_rise_count", 32'(fifo_count), 32'(DEPTH - 1));
          chk("ready_rise_at_stop_pop", 32'(tx_done), 32'd1);
        end
        sb.push_back(tx_data);
        n_acc++;
        @(negedge clk);
        tx_data = tx_data + 8'd1;
      end else begin
        if (!seen_full) begin
          seen_full = 1'b1;
          chk("full_after_accepts", 32'(n_acc), 32'(DEPTH + 1));
          chk("full_count", 32'(fifo_count), 32'(DEPTH));
        end
        @(negedge clk);
      end
      t++;
    end
    tx_valid = 1'b0;
    chk("burst_accepts", 32'(n_acc), 32'd6);
    chk("burst_ready_dropped", 32'(seen_full), 32'd1);
    chk("burst_ready_rose", 32'(seen_rise), 32'd1);
    wait_idle(10 * FRAME);
    chk("burst_frames", 32'(mon_frames - base), 32'd6);
    chk("burst_done", 32'(n_done - d0), 32'd6);
    if (mon_frames >= base + 6)
      chk("burst_span", 32'(mon_end[base + 5] - mon_start[base] + 1), 32'(6 * FRAME));
    else
      chk("burst_span", 32'd0, 32'(6 * FRAME));

    // 4: push lands on the same edge that STOP pops the next byte
    base = mon_frames;
    @(negedge clk);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    sb.push_back(8'hC3);
    @(negedge clk);
    tx_data = 8'h3C;
    sb.push_back(8'h3C);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (FRAME - 1) @(negedge clk);
    chk("pp_count_before", 32'(fifo_count), 32'd1);
    chk("pp_done_before", 32'(tx_done), 32'd0);
    tx_data  = 8'h96;
    tx_valid = 1'b1;
    sb.push_back(8'h96);
    @(negedge clk);
    tx_valid = 1'b0;
    chk("pp_count_after", 32'(fifo_count), 32'd1);
    chk("pp_done_at_pop", 32'(tx_done), 32'd1);
    @(negedge clk);
    chk("pp_next_start", 32'(TxD), 32'd0);
    wait_idle(5 * FRAME);
    chk("pp_frames", 32'(mon_frames - base), 32'd3);

    // 5: reset during data bit 3 of 0xA3 with two bytes queued
    @(negedge clk);
    tx_data  = 8'hA3;
    tx_valid = 1'b1;
    sb.push_back(8'hA3);
    @(negedge clk);
    tx_data = 8'h11;
    sb.push_back(8'h11);
    @(negedge clk);
    tx_data = 8'h22;
    sb.push_back(8'h22);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (4 * DIV + DIV / 2) @(negedge clk);
    chk("mid_txd_bit3", 32'(TxD), 32'd0);
    chk("mid_count", 32'(fifo_count), 32'd2);
    #2 rst = 1'b0;
    #1;
    chk("arst_txd", 32'(TxD), 32'd1);
    chk("arst_count", 32'(fifo_count), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(tx_ready), 32'd1);
    sb.delete();
    base = mon_frames;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bad = 1'b0;
    repeat (3 * FRAME) begin
      @(negedge clk);
      if (TxD !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    chk("no_resume", 32'(bad), 32'd0);
    chk("no_frame_after_rst", 32'(mon_frames - base), 32'd0);

`ifdef BLUETOOTH_TX_PARITY_EN
    // 6: even parity bit between data and stop
    base = mon_frames;
    push(8'h55);
    wait_idle(3 * FRAME);
    push(8'h07);
    wait_idle(3 * FRAME);
    if (mon_frames >= base + 2) begin
      chk("parity_55", 32'(mon_par[base]), 32'd0);
      chk("parity_07", 32'(mon_par[base + 1]), 32'd1);
      chk("parity_len", 32'(mon_end[base + 1] - mon_start[base + 1] + 1), 32'd110);
    end else begin
      chk("parity_frames", 32'(mon_frames - base), 32'd2);
    end
`else
    // extra pattern on the default 8N1 build
    base = mon_frames;
    push(8'h07);
    wait_idle(3 * FRAME);
    chk("pattern_07_frames", 32'(mon_frames - base), 32'd1);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
